led_pio_ctrl: RTL

Parameterised Avalon-MM output port for board LEDs and other static outputs. It is the successor to the fixed 26-bit LED port. It adds atomic set/clear/toggle writes, a configurable reset pattern, and a per-bit hardware blink engine driven by a programmable prescaler, so the CPU can blink LEDs without software timing loops. It sits on the Nios system interconnect as a zero-wait-state slave with read latency 0.

---
 rtl/led_pio_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/led_pio_ctrl.sv
// ---------------------------------------------------------------------------
// led_pio_ctrl
// Avalon-MM output port for board LEDs and other static outputs. Zero-wait
// slave, read latency 0. Supports plain, set, clear and toggle writes to the
// DATA register.
// Optional feature macro: LED_PIO_BLINK_EN
//    defined   -> per-bit blink engine with BLINK_MASK, BLINK_PERIOD, STATUS
//    undefined -> out_port follows DATA, addresses 4..6 read 0
// ---------------------------------------------------------------------------
module led_pio_ctrl #(
   parameter int unsigned      WIDTH        = 26,
   parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
   parameter logic [31:0]      PERIOD_RESET = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_SET    = 3'd1;
   localparam logic [2:0] ADDR_CLEAR  = 3'd2;
   localparam logic [2:0] ADDR_TOGGLE = 3'd3;
   localparam logic [2:0] ADDR_MASK   = 3'd4;
   localparam logic [2:0] ADDR_PERIOD = 3'd5;
   localparam logic [2:0] ADDR_STATUS = 3'd6;

   logic             wr_s;
   logic [WIDTH-1:0] wd_s;
   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] data_nxt_s;
   logic [WIDTH-1:0] out_port_r;
   logic [WIDTH-1:0] out_nxt_s;
   logic             unused_s;

   assign wr_s     = chipselect & ~write_n;
   assign wd_s     = writedata[WIDTH-1:0];
   assign out_port = out_port_r;

   // Upper writedata bits and PERIOD_RESET may be unused in some builds.
   assign unused_s = ^{writedata, PERIOD_RESET};

   // Next DATA value: plain, set, clear or toggle write; otherwise hold.
   always_comb begin
      data_nxt_s = data_r;
      if (wr_s) begin
         case (address)
            ADDR_DATA:   data_nxt_s = wd_s;
            ADDR_SET:    data_nxt_s = data_r | wd_s;
            ADDR_CLEAR:  data_nxt_s = data_r & ~wd_s;
            ADDR_TOGGLE: data_nxt_s = data_r ^ wd_s;
            default:     data_nxt_s = data_r;
         endcase
      end else begin
         data_nxt_s = data_r;
      end
   end

   // DATA register and registered output port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_r     <= RESET_VALUE;
         out_port_r <= RESET_VALUE;
      end else begin
         data_r     <= data_nxt_s;
         out_port_r <= out_nxt_s;
      end
   end

`ifdef LED_PIO_BLINK_EN

   logic [WIDTH-1:0] mask_r;
   logic [WIDTH-1:0] mask_nxt_s;
   logic [31:0]      period_r;
   logic [31:0]      period_nxt_s;
   logic [31:0]      cnt_r;
   logic [31:0]      cnt_nxt_s;
   logic             phase_r;
   logic             phase_nxt_s;

   // Next BLINK_MASK value; mask writes never disturb the counter or phase.
   always_comb begin
      mask_nxt_s = mask_r;
      if (wr_s && (address == ADDR_MASK)) begin
         mask_nxt_s = wd_s;
      end else begin
         mask_nxt_s = mask_r;
      end
   end

   // Blink engine: a period write restarts the counter at phase 0 and wins
   // over a coincident expiry; period 0 parks the engine.
   always_comb begin
      period_nxt_s = period_r;
      cnt_nxt_s    = cnt_r;
      phase_nxt_s  = phase_r;
      if (wr_s && (address == ADDR_PERIOD)) begin
         period_nxt_s = writedata;
         cnt_nxt_s    = writedata;
         phase_nxt_s  = 1'b0;
      end else if (period_r == 32'd0) begin
         cnt_nxt_s    = 32'd0;
         phase_nxt_s  = 1'b0;
      end else if (cnt_r == 32'd0) begin
         cnt_nxt_s    = period_r;
         phase_nxt_s  = ~phase_r;
      end else begin
         cnt_nxt_s    = cnt_r - 32'd1;
         phase_nxt_s  = phase_r;
      end
   end

   // Blink engine state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_r   <= {WIDTH{1'b0}};
         period_r <= PERIOD_RESET;
         cnt_r    <= PERIOD_RESET;
         phase_r  <= 1'b0;
      end else begin
         mask_r   <= mask_nxt_s;
         period_r <= period_nxt_s;
         cnt_r    <= cnt_nxt_s;
         phase_r  <= phase_nxt_s;
      end
   end

   // Output value for the next cycle: DATA with blinking bits inverted in phase 1.
   always_comb begin
      out_nxt_s = data_nxt_s ^ (mask_nxt_s & {WIDTH{phase_nxt_s}});
   end

   // Combinational read mux; write-only and reserved addresses read 0.
   always_comb begin
      readdata = 32'h0000_0000;
      case (address)
         ADDR_DATA:   readdata = 32'(data_r);
         ADDR_MASK:   readdata = 32'(mask_r);
         ADDR_PERIOD: readdata = period_r;
         ADDR_STATUS: readdata = {31'd0, phase_r};
         default:     readdata = 32'h0000_0000;
      endcase
   end

`else

   // Without the blink engine the outputs simply follow DATA.
   always_comb begin
      out_nxt_s = data_nxt_s;
   end

   // Combinational read mux; only DATA is readable.
   always_comb begin
      readdata = 32'h0000_0000;
      case (address)
         ADDR_DATA: readdata = 32'(data_r);
         default:   readdata = 32'h0000_0000;
      endcase
   end

`endif

endmodule
